// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Hazard FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MDUWAIT = 2'd2
    } state_e;

    // Execute-stage operand source selects.
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle.
interface hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5
);
    logic [REG_AW-1:0] ra1D;
    logic [REG_AW-1:0] ra2D;
    logic [REG_AW-1:0] ra1E;
    logic [REG_AW-1:0] ra2E;
    logic [REG_AW-1:0] rdE;
    logic [REG_AW-1:0] rdM;
    logic [REG_AW-1:0] rdW;
    logic              memtoregE;
    logic              regwriteM;
    logic              regwriteW;
    logic              controlChange;
    logic              mduStartE;
    logic              mduDoneE;
    logic              memReadyM;

    logic              stallF;
    logic              stallD;
    logic              stallE;
    logic              stallM;
    logic              flushD;
    logic              flushE;
    logic              flushM;
    logic              flushW;
    logic [1:0]        forwardAE;
    logic [1:0]        forwardBE;
    logic              busy;

    // Pipeline side: supplies stage info, receives controls.
    modport master (
        output ra1D, ra2D, ra1E, ra2E, rdE, rdM, rdW,
        output memtoregE, regwriteM, regwriteW, controlChange,
        output mduStartE, mduDoneE, memReadyM,
        input  stallF, stallD, stallE, stallM,
        input  flushD, flushE, flushM, flushW,
        input  forwardAE, forwardBE, busy
    );

    // Hazard controller side.
    modport slave (
        input  ra1D, ra2D, ra1E, ra2E, rdE, rdM, rdW,
        input  memtoregE, regwriteM, regwriteW, controlChange,
        input  mduStartE, mduDoneE, memReadyM,
        output stallF, stallD, stallE, stallM,
        output flushD, flushE, flushM, flushW,
        output forwardAE, forwardBE, busy
    );

endinterface

// File: rtl/fwd_sel.sv
// Operand forwarding select for one execute-stage source register.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW         = 5,
    parameter bit          ZERO_HARDWIRED = 1'b1
) (
    input  logic [REG_AW-1:0] ra_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    output logic [1:0]        fwd_c
);

    // Youngest producer wins: M before W; r0 never forwards when hardwired.
    always_comb begin
        fwd_c = FWD_NONE;
        if (ZERO_HARDWIRED && (ra_e == '0)) begin
            fwd_c = FWD_NONE;
        end else if (regwrite_m && (rd_m == ra_e)) begin
            fwd_c = FWD_M;
        end else if (regwrite_w && (rd_w == ra_e)) begin
            fwd_c = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, MDU wait, memory wait.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW         = 5,
    parameter int unsigned LOAD_LAT       = 1,
    parameter bit          ZERO_HARDWIRED = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    localparam int unsigned CNT_W = $clog2(LOAD_LAT + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;

    logic               load_use_c;
    logic [1:0]         fwd_a_c, fwd_b_c;
    logic               stall_f_c, stall_d_c, stall_e_c, stall_m_c;
    logic               flush_d_c, flush_e_c, flush_m_c, flush_w_c;

    fwd_sel #(
        .REG_AW         (REG_AW),
        .ZERO_HARDWIRED (ZERO_HARDWIRED)
    ) u_fwd_a (
        .ra_e       (hz.ra1E),
        .rd_m       (hz.rdM),
        .rd_w       (hz.rdW),
        .regwrite_m (hz.regwriteM),
        .regwrite_w (hz.regwriteW),
        .fwd_c      (fwd_a_c)
    );

    fwd_sel #(
        .REG_AW         (REG_AW),
        .ZERO_HARDWIRED (ZERO_HARDWIRED)
    ) u_fwd_b (
        .ra_e       (hz.ra2E),
        .rd_m       (hz.rdM),
        .rd_w       (hz.rdW),
        .regwrite_m (hz.regwriteM),
        .regwrite_w (hz.regwriteW),
        .fwd_c      (fwd_b_c)
    );

    // Load in E whose destination a decode-stage instruction reads.
    assign load_use_c = hz.memtoregE && (hz.rdE != '0) &&
                        ((hz.ra1D == hz.rdE) || (hz.ra2D == hz.rdE));

    // Next state, stall counter and per-cycle stall/flush controls.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_f_c = 1'b0;
        stall_d_c = 1'b0;
        stall_e_c = 1'b0;
        stall_m_c = 1'b0;
        flush_d_c = 1'b0;
        flush_e_c = 1'b0;
        flush_m_c = 1'b0;
        flush_w_c = 1'b0;

        if (!hz.memReadyM) begin
            // Memory wait freezes the whole pipe and the FSM; W gets a bubble.
            stall_f_c = 1'b1;
            stall_d_c = 1'b1;
            stall_e_c = 1'b1;
            stall_m_c = 1'b1;
            flush_w_c = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hz.controlChange) begin
                        flush_d_c = 1'b1;
                        flush_e_c = 1'b1;
                    end else if (hz.mduStartE && !hz.mduDoneE) begin
                        stall_f_c = 1'b1;
                        stall_d_c = 1'b1;
                        stall_e_c = 1'b1;
                        flush_m_c = 1'b1;
                        state_d   = ST_MDUWAIT;
                    end else if (load_use_c) begin
                        stall_f_c = 1'b1;
                        stall_d_c = 1'b1;
                        flush_e_c = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = ST_LDSTALL;
                            cnt_d   = CNT_W'(LOAD_LAT - 1);
                        end
                    end
                end
                ST_LDSTALL: begin
                    if (hz.controlChange) begin
                        // Redirect squashes the stalled instruction; let F reload.
                        flush_d_c = 1'b1;
                        flush_e_c = 1'b1;
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                    end else begin
                        stall_f_c = 1'b1;
                        stall_d_c = 1'b1;
                        flush_e_c = 1'b1;
                        if (cnt_q <= CNT_W'(1)) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                ST_MDUWAIT: begin
                    if (!hz.mduDoneE) begin
                        stall_f_c = 1'b1;
                        stall_d_c = 1'b1;
                        stall_e_c = 1'b1;
                        flush_m_c = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, counter and busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Controls are same-cycle; held quiet while reset is asserted.
    assign hz.stallF    = stall_f_c & ~reset;
    assign hz.stallD    = stall_d_c & ~reset;
    assign hz.stallE    = stall_e_c & ~reset;
    assign hz.stallM    = stall_m_c & ~reset;
    assign hz.flushD    = flush_d_c & ~reset;
    assign hz.flushE    = flush_e_c & ~reset;
    assign hz.flushM    = flush_m_c & ~reset;
    assign hz.flushW    = flush_w_c & ~reset;
    assign hz.forwardAE = reset ? FWD_NONE : fwd_a_c;
    assign hz.forwardBE = reset ? FWD_NONE : fwd_b_c;
    assign hz.busy      = busy_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: LOAD_LAT=3 and LOAD_LAT=4 instances side by side.
module tb_hazard_ctrl;

    logic clk;
    logic reset;

    hazard_ctrl_if #(.REG_AW(5)) if_a ();
    hazard_ctrl_if #(.REG_AW(5)) if_b ();

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .ZERO_HARDWIRED(1'b1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .hz    (if_a)
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(4), .ZERO_HARDWIRED(1'b1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .hz    (if_b)
    );

    // Both instances see identical stimulus.
    assign if_b.ra1D          = if_a.ra1D;
    assign if_b.ra2D          = if_a.ra2D;
    assign if_b.ra1E          = if_a.ra1E;
    assign if_b.ra2E          = if_a.ra2E;
    assign if_b.rdE           = if_a.rdE;
    assign if_b.rdM           = if_a.rdM;
    assign if_b.rdW           = if_a.rdW;
    assign if_b.memtoregE     = if_a.memtoregE;
    assign if_b.regwriteM     = if_a.regwriteM;
    assign if_b.regwriteW     = if_a.regwriteW;
    assign if_b.controlChange = if_a.controlChange;
    assign if_b.mduStartE     = if_a.mduStartE;
    assign if_b.mduDoneE      = if_a.mduDoneE;
    assign if_b.memReadyM     = if_a.memReadyM;

    // Output vector: {stallF,D,E,M, flushD,E,M,W, busy, forwardAE, forwardBE}
    logic [12:0] out_a, out_b;
    assign out_a = {if_a.stallF, if_a.stallD, if_a.stallE, if_a.stallM,
                    if_a.flushD, if_a.flushE, if_a.flushM, if_a.flushW,
                    if_a.busy, if_a.forwardAE, if_a.forwardBE};
    assign out_b = {if_b.stallF, if_b.stallD, if_b.stallE, if_b.stallM,
                    if_b.flushD, if_b.flushE, if_b.flushM, if_b.flushW,
                    if_b.busy, if_b.forwardAE, if_b.forwardBE};

    localparam logic [3:0] S_NO  = 4'b0000;
    localparam logic [3:0] S_FD  = 4'b1100;
    localparam logic [3:0] S_FDE = 4'b1110;
    localparam logic [3:0] S_ALL = 4'b1111;
    localparam logic [3:0] F_NO  = 4'b0000;
    localparam logic [3:0] F_E   = 4'b0100;
    localparam logic [3:0] F_DE  = 4'b1100;
    localparam logic [3:0] F_M   = 4'b0010;
    localparam logic [3:0] F_W   = 4'b0001;

    typedef struct {
        string       name;
        int          dut;
        logic [12:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] mk(input logic [3:0] st, input logic [3:0] fl,
                                       input logic b, input logic [1:0] fa,
                                       input logic [1:0] fb);
        return {st, fl, b, fa, fb};
    endfunction

    // Reference forwarding rule.
    function automatic logic [1:0] fwd_model(input logic [4:0] ra, input logic [4:0] rdm,
                                             input logic rwm, input logic [4:0] rdw,
                                             input logic rww);
        if (ra == 5'd0) return 2'b00;
        if (rwm && (rdm == ra)) return 2'b10;
        if (rww && (rdw == ra)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic push2(input string name, input logic [12:0] va, input logic [12:0] vb);
        exp_t e;
        e.name = name; e.dut = 0; e.v = va; sb.push_back(e);
        e.name = name; e.dut = 1; e.v = vb; sb.push_back(e);
    endtask

    task automatic idle_inputs();
        if_a.ra1D = '0; if_a.ra2D = '0; if_a.ra1E = '0; if_a.ra2E = '0;
        if_a.rdE = '0; if_a.rdM = '0; if_a.rdW = '0;
        if_a.memtoregE = 1'b0; if_a.regwriteM = 1'b0; if_a.regwriteW = 1'b0;
        if_a.controlChange = 1'b0; if_a.mduStartE = 1'b0; if_a.mduDoneE = 1'b0;
        if_a.memReadyM = 1'b1;
    endtask

    task automatic load_use_inputs();
        if_a.memtoregE = 1'b1; if_a.rdE = 5'd7; if_a.ra2D = 5'd7; if_a.ra1D = 5'd2;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [12:0] got;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            idle_inputs();
            if (c < 2) begin
                reset = 1'b1;
                load_use_inputs();
                if_a.ra1E = 5'd5; if_a.rdM = 5'd5; if_a.regwriteM = 1'b1;
                if_a.mduStartE = 1'b1; if_a.controlChange = 1'b1; if_a.memReadyM = 1'b0;
            end else begin
                reset = 1'b0;
            end
            push2(c < 2 ? "reset_hold" : "post_reset", '0, '0);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = (e.dut == 0) ? out_a : out_b;
                n_checks++;
                if (got !== e.v) begin
                    n_fail++;
                    $display("FAIL %s dut%0d cyc%0d: got %b expected %b", e.name, e.dut, c, got, e.v);
                end
            end
        end
    endtask

    task automatic test_forwarding();
        exp_t e;
        logic [12:0] got, v;
        logic [1:0] fa, fb;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            idle_inputs();
            case (c)
                0: begin if_a.ra1E = 5'd5; if_a.rdM = 5'd5; if_a.regwriteM = 1'b1;
                         if_a.rdW = 5'd5; if_a.regwriteW = 1'b1; end
                1: begin if_a.ra1E = 5'd5; if_a.rdM = 5'd5; if_a.regwriteM = 1'b0;
                         if_a.rdW = 5'd5; if_a.regwriteW = 1'b1; end
                2: begin if_a.ra1E = 5'd0; if_a.rdM = 5'd0; if_a.regwriteM = 1'b1;
                         if_a.rdW = 5'd0; if_a.regwriteW = 1'b1; end
                3: begin if_a.ra2E = 5'd6; if_a.rdM = 5'd9; if_a.regwriteM = 1'b1;
                         if_a.rdW = 5'd6; if_a.regwriteW = 1'b1; end
                default: begin
                    if_a.ra1E = 5'($urandom_range(0, 3));
                    if_a.ra2E = 5'($urandom_range(0, 3));
                    if_a.rdM  = 5'($urandom_range(0, 3));
                    if_a.rdW  = 5'($urandom_range(0, 3));
                    if_a.regwriteM = 1'($urandom_range(0, 1));
                    if_a.regwriteW = 1'($urandom_range(0, 1));
                end
            endcase
            case (c)
                0: begin fa = 2'b10; fb = 2'b00; end
                1: begin fa = 2'b01; fb = 2'b00; end
                2: begin fa = 2'b00; fb = 2'b00; end
                3: begin fa = 2'b00; fb = 2'b01; end
                default: begin
                    fa = fwd_model(if_a.ra1E, if_a.rdM, if_a.regwriteM, if_a.rdW, if_a.regwriteW);
                    fb = fwd_model(if_a.ra2E, if_a.rdM, if_a.regwriteM, if_a.rdW, if_a.regwriteW);
                end
            endcase
            v = mk(S_NO, F_NO, 1'b0, fa, fb);
            push2("forward", v, v);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = (e.dut == 0) ? out_a : out_b;
                n_checks++;
                if (got !== e.v) begin
                    n_fail++;
                    $display("FAIL %s dut%0d cyc%0d: got %b expected %b", e.name, e.dut, c, got, e.v);
                end
            end
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        logic [12:0] got;
        logic [5:0] st_a = 6'b000111;
        logic [5:0] bz_a = 6'b000110;
        logic [5:0] st_b = 6'b001111;
        logic [5:0] bz_b = 6'b001110;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            idle_inputs();
            if (c == 0) load_use_inputs();
            if (c == 5) begin
                if_a.memtoregE = 1'b1; if_a.rdE = 5'd0; if_a.ra1D = 5'd0; if_a.ra2D = 5'd0;
            end
            push2("load_use",
                  mk(st_a[c] ? S_FD : S_NO, st_a[c] ? F_E : F_NO, bz_a[c], 2'b00, 2'b00),
                  mk(st_b[c] ? S_FD : S_NO, st_b[c] ? F_E : F_NO, bz_b[c], 2'b00, 2'b00));
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = (e.dut == 0) ? out_a : out_b;
                n_checks++;
                if (got !== e.v) begin
                    n_fail++;
                    $display("FAIL %s dut%0d cyc%0d: got %b expected %b", e.name, e.dut, c, got, e.v);
                end
            end
        end
    endtask

    task automatic test_mdu();
        exp_t e;
        logic [12:0] got, v;
        logic [7:0] st = 8'b00001111;
        logic [7:0] bz = 8'b00011110;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            idle_inputs();
            if (c <= 4 || c == 6) if_a.mduStartE = 1'b1;
            if (c == 4 || c == 6) if_a.mduDoneE = 1'b1;
            if (c == 2) if_a.controlChange = 1'b1;
            v = mk(st[c] ? S_FDE : S_NO, st[c] ? F_M : F_NO, bz[c], 2'b00, 2'b00);
            push2("mdu", v, v);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = (e.dut == 0) ? out_a : out_b;
                n_checks++;
                if (got !== e.v) begin
                    n_fail++;
                    $display("FAIL %s dut%0d cyc%0d: got %b expected %b", e.name, e.dut, c, got, e.v);
                end
            end
        end
    endtask

    task automatic test_ctrl_change();
        exp_t e;
        logic [12:0] got, v;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            idle_inputs();
            case (c)
                0: begin load_use_inputs(); v = mk(S_FD, F_E, 1'b0, 2'b00, 2'b00); end
                1: begin if_a.controlChange = 1'b1; v = mk(S_NO, F_DE, 1'b1, 2'b00, 2'b00); end
                2: v = mk(S_NO, F_NO, 1'b0, 2'b00, 2'b00);
                3: begin load_use_inputs(); if_a.controlChange = 1'b1;
                         v = mk(S_NO, F_DE, 1'b0, 2'b00, 2'b00); end
                default: v = mk(S_NO, F_NO, 1'b0, 2'b00, 2'b00);
            endcase
            push2("ctrl_change", v, v);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = (e.dut == 0) ? out_a : out_b;
                n_checks++;
                if (got !== e.v) begin
                    n_fail++;
                    $display("FAIL %s dut%0d cyc%0d: got %b expected %b", e.name, e.dut, c, got, e.v);
                end
            end
        end
    endtask

    task automatic test_mem_stall();
        exp_t e;
        logic [12:0] got, v;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            idle_inputs();
            case (c)
                0: begin if_a.mduStartE = 1'b1; v = mk(S_FDE, F_M, 1'b0, 2'b00, 2'b00); end
                1: begin if_a.mduStartE = 1'b1; v = mk(S_FDE, F_M, 1'b1, 2'b00, 2'b00); end
                2: begin if_a.mduStartE = 1'b1; if_a.memReadyM = 1'b0;
                         if_a.ra1E = 5'd5; if_a.rdM = 5'd5; if_a.regwriteM = 1'b1;
                         v = mk(S_ALL, F_W, 1'b1, 2'b10, 2'b00); end
                3: begin if_a.mduStartE = 1'b1; if_a.mduDoneE = 1'b1; if_a.memReadyM = 1'b0;
                         v = mk(S_ALL, F_W, 1'b1, 2'b00, 2'b00); end
                4: begin if_a.mduStartE = 1'b1; v = mk(S_FDE, F_M, 1'b1, 2'b00, 2'b00); end
                5: begin if_a.mduStartE = 1'b1; if_a.mduDoneE = 1'b1;
                         v = mk(S_NO, F_NO, 1'b1, 2'b00, 2'b00); end
                6: v = mk(S_NO, F_NO, 1'b0, 2'b00, 2'b00);
                7: begin load_use_inputs(); if_a.memReadyM = 1'b0;
                         v = mk(S_ALL, F_W, 1'b0, 2'b00, 2'b00); end
                default: v = mk(S_NO, F_NO, 1'b0, 2'b00, 2'b00);
            endcase
            push2("mem_stall", v, v);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = (e.dut == 0) ? out_a : out_b;
                n_checks++;
                if (got !== e.v) begin
                    n_fail++;
                    $display("FAIL %s dut%0d cyc%0d: got %b expected %b", e.name, e.dut, c, got, e.v);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [12:0] got, v;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            idle_inputs();
            case (c)
                0: begin load_use_inputs(); v = mk(S_FD, F_E, 1'b0, 2'b00, 2'b00); end
                1: v = mk(S_FD, F_E, 1'b1, 2'b00, 2'b00);
                2: begin reset = 1'b1; load_use_inputs();
                         if_a.ra1E = 5'd5; if_a.rdM = 5'd5; if_a.regwriteM = 1'b1;
                         v = '0; end
                default: begin reset = 1'b0; v = mk(S_NO, F_NO, 1'b0, 2'b00, 2'b00); end
            endcase
            push2("reset_mid", v, v);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = (e.dut == 0) ? out_a : out_b;
                n_checks++;
                if (got !== e.v) begin
                    n_fail++;
                    $display("FAIL %s dut%0d cyc%0d: got %b expected %b", e.name, e.dut, c, got, e.v);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mdu();
        test_ctrl_change();
        test_mem_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Run-length guard.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
